// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing defaults and flag types for the RAM-backed FIFO controller.
package fifo_pkg;
    localparam int FIFO_DW       = 8;
    localparam int FIFO_AW       = 7;
    localparam int FIFO_DEPTH    = 1 << FIFO_AW;
    localparam int FIFO_AF_LEVEL = 120;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// FIFO user port plus the dual-port RAM port of the FIFO controller.
interface ram_fifo_ctrl_if import fifo_pkg::*; #(
    parameter int DW = FIFO_DW,
    parameter int AW = FIFO_AW
) ();
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic [AW-1:0] ram_a1;
    logic [DW-1:0] ram_d1;
    logic          ram_we1;
    logic [AW-1:0] ram_a2;
    logic [DW-1:0] ram_q2;

    modport slave (
        input  flush, wr_en, wr_data, rd_en, ram_q2,
        output full, almost_full, rd_data, rd_valid, empty, count, ovf, udf,
               ram_a1, ram_d1, ram_we1, ram_a2
    );

    modport master (
        output flush, wr_en, wr_data, rd_en, ram_q2,
        input  full, almost_full, rd_data, rd_valid, empty, count, ovf, udf,
               ram_a1, ram_d1, ram_we1, ram_a2
    );
endinterface

// File: rtl/ram_fifo_ctrl_ptr.sv
// AW-bit wrapping pointer with synchronous clear (clear wins over increment).
module fifo_ptr import fifo_pkg::*; #(
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM with registered read port.
// Occupancy is tracked in a count register; flags decode from it combinationally.
module ram_fifo_ctrl import fifo_pkg::*; #(
    parameter int DW       = FIFO_DW,
    parameter int AW       = FIFO_AW,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_fifo_ctrl_if.slave  bus
);
    logic          push_ok;
    logic          pop_ok;
    logic          full_w;
    logic          empty_w;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          rd_valid_q;
    fifo_err_t     err_q;
    fifo_err_t     err_d;

    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign empty_w = (count_q == '0);

    // rst_n is folded in so a write in flight is dropped during reset.
    assign push_ok = bus.wr_en && !full_w  && !bus.flush && rst_n;
    assign pop_ok  = bus.rd_en && !empty_w && !bus.flush && rst_n;

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (push_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (bus.flush) begin
            count_d = '0;
            err_d   = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            if (bus.wr_en && full_w) begin
                err_d.ovf = 1'b1;
            end
            if (bus.rd_en && empty_w) begin
                err_d.udf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            err_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            err_q      <= err_d;
            rd_valid_q <= pop_ok;
        end
    end

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almost_full = (count_q >= (AW+1)'(AF_LEVEL));
    assign bus.count       = count_q;
    assign bus.ovf         = err_q.ovf;
    assign bus.udf         = err_q.udf;
    assign bus.rd_valid    = rd_valid_q;
    // RAM read port is already registered, so its output lines up with rd_valid.
    assign bus.rd_data     = DW'(bus.ram_q2);
    assign bus.ram_we1     = push_ok;
    assign bus.ram_a1      = wr_ptr;
    assign bus.ram_d1      = DW'(bus.wr_data);
    assign bus.ram_a2      = rd_ptr;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural registered-read RAM.
module tb_ram_fifo_ctrl;
    import fifo_pkg::*;

    localparam int DW = FIFO_DW;
    localparam int AW = FIFO_AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    ram_fifo_ctrl #(
        .DW       (DW),
        .AW       (AW),
        .DEPTH    (FIFO_DEPTH),
        .AF_LEVEL (FIFO_AF_LEVEL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [FIFO_DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we1) mem[bus.ram_a1] <= bus.ram_d1;
        bus.ram_q2 <= mem[bus.ram_a2];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic fl, input logic we, input logic [7:0] d, input logic re);
        bus.flush   = fl;
        bus.wr_en   = we;
        bus.wr_data = d;
        bus.rd_en   = re;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       fl;
        logic       we;
        logic [7:0] d;
        logic       re;
        logic       exp_we1;
        logic [7:0] exp_cnt;
        logic       exp_empty;
        logic       exp_rv;
        logic [7:0] exp_data;
        logic       exp_udf;
    } vec_t;

    vec_t vecs [14];
    logic [7:0] model_q [$];
    logic [7:0] exp_v;
    logic [7:0] val;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           fl we data   re  we1 cnt e  rv data   udf
        vecs[0]  = '{0, 1, 8'h11, 0,  1,  1,  0, 0, 8'h00, 0};
        vecs[1]  = '{0, 1, 8'h22, 0,  1,  2,  0, 0, 8'h00, 0};
        vecs[2]  = '{0, 1, 8'h33, 0,  1,  3,  0, 0, 8'h00, 0};
        vecs[3]  = '{0, 0, 8'h00, 1,  0,  2,  0, 1, 8'h11, 0};
        vecs[4]  = '{0, 0, 8'h00, 1,  0,  1,  0, 1, 8'h22, 0};
        vecs[5]  = '{0, 0, 8'h00, 1,  0,  0,  1, 1, 8'h33, 0};
        vecs[6]  = '{0, 0, 8'h00, 0,  0,  0,  1, 0, 8'h00, 0};
        vecs[7]  = '{0, 1, 8'hA5, 1,  1,  1,  0, 0, 8'h00, 1};
        vecs[8]  = '{0, 0, 8'h00, 1,  0,  0,  1, 1, 8'hA5, 1};
        vecs[9]  = '{0, 0, 8'h00, 0,  0,  0,  1, 0, 8'h00, 1};
        vecs[10] = '{0, 1, 8'h5A, 0,  1,  1,  0, 0, 8'h00, 1};
        vecs[11] = '{0, 1, 8'h6B, 1,  1,  1,  0, 1, 8'h5A, 1};
        vecs[12] = '{0, 0, 8'h00, 1,  0,  0,  1, 1, 8'h6B, 1};
        vecs[13] = '{1, 0, 8'h00, 0,  0,  0,  1, 0, 8'h00, 0};

        rst_n = 1'b0;
        apply(0, 0, 8'h00, 0);
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_rv", 32'(bus.rd_valid), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_udf", 32'(bus.udf), 0);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].fl, vecs[i].we, vecs[i].d, vecs[i].re);
            chk($sformatf("v%0d_we1", i), 32'(bus.ram_we1), 32'(vecs[i].exp_we1));
            tick();
            chk($sformatf("v%0d_cnt", i), 32'(bus.count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
            chk($sformatf("v%0d_rv", i), 32'(bus.rd_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv)
                chk($sformatf("v%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_udf", i), 32'(bus.udf), 32'(vecs[i].exp_udf));
        end

        // Fill to full, watching the almost_full threshold.
        for (int i = 0; i < 128; i++) begin
            apply(0, 1, 8'(i), 0);
            chk($sformatf("fill%0d_we1", i), 32'(bus.ram_we1), 1);
            tick();
            chk($sformatf("fill%0d_cnt", i), 32'(bus.count), 32'(i + 1));
            chk($sformatf("fill%0d_af", i), 32'(bus.almost_full), 32'((i + 1) >= 120));
            chk($sformatf("fill%0d_full", i), 32'(bus.full), 32'((i + 1) == 128));
        end
        apply(0, 1, 8'hEE, 0);
        chk("ovf_push_we1", 32'(bus.ram_we1), 0);
        tick();
        chk("ovf_set", 32'(bus.ovf), 1);
        chk("ovf_cnt", 32'(bus.count), 128);
        chk("ovf_full", 32'(bus.full), 1);

        // Push and pop while full: pop taken, push rejected.
        apply(0, 1, 8'hDD, 1);
        chk("fullpp_we1", 32'(bus.ram_we1), 0);
        tick();
        chk("fullpp_cnt", 32'(bus.count), 127);
        chk("fullpp_rv", 32'(bus.rd_valid), 1);
        chk("fullpp_data", 32'(bus.rd_data), 0);
        chk("fullpp_ovf", 32'(bus.ovf), 1);
        for (int i = 1; i < 128; i++) begin
            apply(0, 0, 8'h00, 1);
            tick();
            chk($sformatf("drain%0d_rv", i), 32'(bus.rd_valid), 1);
            chk($sformatf("drain%0d_data", i), 32'(bus.rd_data), 32'(i));
        end
        chk("drain_cnt", 32'(bus.count), 0);
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_ovf", 32'(bus.ovf), 1);

        apply(0, 0, 8'h00, 1);
        tick();
        chk("udf_rv", 32'(bus.rd_valid), 0);
        chk("udf_set", 32'(bus.udf), 1);

        // Flush with push and pop asserted.
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 8'(8'h30 + i), 0);
            tick();
        end
        chk("pre_flush_cnt", 32'(bus.count), 10);
        apply(1, 1, 8'h99, 1);
        chk("flush_we1", 32'(bus.ram_we1), 0);
        tick();
        chk("flush_cnt", 32'(bus.count), 0);
        chk("flush_empty", 32'(bus.empty), 1);
        chk("flush_rv", 32'(bus.rd_valid), 0);
        chk("flush_ovf", 32'(bus.ovf), 0);
        chk("flush_udf", 32'(bus.udf), 0);
        chk("flush_a1", 32'(bus.ram_a1), 0);
        chk("flush_a2", 32'(bus.ram_a2), 0);

        // Fill to 64 then stream push+pop long enough to wrap both pointers.
        for (int i = 0; i < 64; i++) begin
            val = 8'(8'h40 + i);
            apply(0, 1, val, 0);
            tick();
            model_q.push_back(val);
        end
        chk("wrap_fill_cnt", 32'(bus.count), 64);
        for (int k = 0; k < 200; k++) begin
            val = 8'(k * 7 + 3);
            apply(0, 1, val, 1);
            tick();
            exp_v = model_q.pop_front();
            model_q.push_back(val);
            chk($sformatf("wrap%0d_rv", k), 32'(bus.rd_valid), 1);
            chk($sformatf("wrap%0d_data", k), 32'(bus.rd_data), 32'(exp_v));
            chk($sformatf("wrap%0d_cnt", k), 32'(bus.count), 64);
        end

        // Reset for one cycle in the middle of a burst, right after an accepted pop.
        apply(0, 1, 8'h77, 1);
        tick();
        chk("burst_rv", 32'(bus.rd_valid), 1);
        rst_n = 1'b0;
        apply(0, 1, 8'h55, 1);
        chk("rst_we1", 32'(bus.ram_we1), 0);
        tick();
        chk("mrst_cnt", 32'(bus.count), 0);
        chk("mrst_empty", 32'(bus.empty), 1);
        chk("mrst_full", 32'(bus.full), 0);
        chk("mrst_af", 32'(bus.almost_full), 0);
        chk("mrst_rv", 32'(bus.rd_valid), 0);
        chk("mrst_ovf", 32'(bus.ovf), 0);
        chk("mrst_udf", 32'(bus.udf), 0);
        chk("mrst_a1", 32'(bus.ram_a1), 0);
        chk("mrst_a2", 32'(bus.ram_a2), 0);
        rst_n = 1'b1;
        apply(0, 1, 8'h42, 0);
        tick();
        apply(0, 0, 8'h00, 1);
        tick();
        chk("post_rst_rv", 32'(bus.rd_valid), 1);
        chk("post_rst_data", 32'(bus.rd_data), 32'h42);
        chk("post_rst_cnt", 32'(bus.count), 0);
        apply(0, 0, 8'h00, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- DW, 8, data width.
- AW, 7, RAM address width.
- DEPTH, 128, entries (2**AW).
- AF_LEVEL, 120, almost_full threshold.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; also drives both RAM clocks externally.
- rst_n, in, 1, synchronous active-low reset.
- flush, in, 1, synchronous clear of FIFO state.
- wr_en, in, 1, push request.
- wr_data, in, DW, push data.
- full, out, 1, count == DEPTH.
- almost_full, out, 1, count >= AF_LEVEL.
- rd_en, in, 1, pop request.
- rd_data, out, DW, popped data; valid when rd_valid is high.
- rd_valid, out, 1, rd_data qualifier.
- empty, out, 1, count == 0.
- count, out, AW+1, occupancy.
- ovf, out, 1, sticky push-while-full flag.
- udf, out, 1, sticky pop-while-empty flag.
- ram_a1, out, AW, RAM write address.
- ram_d1, out, DW, RAM write data.
- ram_we1, out, 1, RAM write enable.
- ram_a2, out, AW, RAM read address.
- ram_q2, in, DW, RAM read data (registered in RAM, 1-cycle latency).

Function
REQ-004 push_ok SHALL equal wr_en && !full && !flush && rst_n; pop_ok SHALL equal rd_en && !empty && !flush && rst_n.
REQ-005 ram_we1 SHALL equal push_ok, ram_a1 SHALL equal wr_ptr, and ram_d1 SHALL equal wr_data, all combinational.
REQ-006 ram_a2 SHALL equal rd_ptr combinationally at all times.
REQ-007 On push_ok, wr_ptr SHALL increment by 1 modulo DEPTH (127 wraps to 0).
REQ-008 On pop_ok, rd_ptr SHALL increment by 1 modulo DEPTH.
REQ-009 rd_valid SHALL be a register loaded with pop_ok, so it is high exactly one cycle after each accepted pop.
REQ-010 rd_data SHALL equal ram_q2, giving a pop-to-data latency of 1 cycle.
REQ-011 count SHALL update as follows:
- +1 on push_ok only.
- -1 on pop_ok only.
- unchanged when both or neither occur.
REQ-012 Push and pop accepted together (FIFO neither empty nor full) SHALL both take effect and leave count unchanged.
REQ-013 A push while full SHALL be rejected even if a pop is accepted in the same cycle; no write occurs and ovf is set.
REQ-014 A pop while empty SHALL be rejected even if a push is accepted in the same cycle; udf is set and rd_valid stays low the next cycle.
REQ-015 full, empty and almost_full SHALL be decoded combinationally from the count register.
REQ-016 ovf and udf SHALL remain set until reset or flush.
REQ-017 flush SHALL have priority over push and pop, and on the next edge SHALL clear:
- wr_ptr, rd_ptr and count to 0.
- ovf and udf to 0.
- rd_valid to 0.
REQ-018 RAM contents SHALL NOT be cleared by flush or reset; stale data is never presented, because rd_valid gates it.

Reset
REQ-019 While rst_n is low at a clk edge, the block SHALL set:
- wr_ptr, rd_ptr and count to 0.
- rd_valid, ovf and udf to 0.
REQ-020 After reset, empty SHALL be 1 and full and almost_full SHALL be 0.
REQ-021 While rst_n is low, ram_we1 SHALL be 0, so a reset asserted mid-operation aborts the pending write.
REQ-022 A pop accepted in the cycle before reset asserts SHALL NOT produce rd_valid after reset.

Structure
REQ-023 DW, AW, DEPTH and AF_LEVEL defaults SHALL live in shared package fifo_pkg, and the RAM instance SHALL use the same AW and DW.
REQ-024 Pointer logic SHALL be one reusable sub-module, fifo_ptr: an AW-bit wrapping counter with increment and synchronous clear, instantiated twice.
REQ-025 The RAM SHALL be instantiated outside this block, with clk driving both RAM clocks, so the whole pair runs on one clock.

Verification
REQ-026 Reset then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times -> rd_valid on 3 consecutive cycles, each one cycle after its pop, with rd_data 0x11, 0x22, 0x33, then empty=1 and count=0.
REQ-027 Push 128 values 0x00..0x7F -> full=1, almost_full high from count=120, count=128; a 129th push -> ram_we1=0, ovf=1, count stays 128.
REQ-028 Pop on an empty FIFO while pushing 0xA5 in the same cycle -> udf=1, no rd_valid next cycle, count=1; the next pop returns 0xA5.
REQ-029 Fill to 64, then push and pop together for 200 cycles (pointers wrap) -> count stays 64 and data order is preserved.
REQ-030 Fill to 10, assert flush together with wr_en and rd_en -> next cycle count=0, empty=1, rd_valid=0, ovf=udf=0, and no RAM write.
REQ-031 Drop rst_n for one cycle during a push/pop burst -> all state returns to its reset values, and ram_we1=0 during the reset cycle.
